// File: rtl/dmem_pkg.sv
// Shared types and geometry helpers for the byte-addressable data memory.
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enables and an asynchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                       clk,
  input  logic [$clog2(DEPTH)-1:0]   index,
  input  logic [DATA_WIDTH/8-1:0]    lane_en,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_en[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/byte_data_mem.sv
// Byte-enabled data memory: clears itself after reset, then serves aligned word requests.
// Optional macro DMEM_WR_FORWARD_EN: same-address read-during-write returns the new word.
module byte_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    writeEn,
  input  logic                    readEn,
  input  logic [ADDR_WIDTH-1:0]   ALUMemAdd,
  input  logic [DATA_WIDTH-1:0]   writeDataM,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  output logic [DATA_WIDTH-1:0]   readDataW,
  output logic                    readValid,
  output logic                    addrErr,
  output logic                    memReady
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned OFF_W = off_width(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t state, state_next;
  logic [IDX_W-1:0]      clr_idx;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      arr_idx;
  logic [LANES-1:0]      wr_lanes;
  logic [LANES-1:0]      arr_en;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  legal;
  logic                  ready;

  // Shifting out the index field leaves only the bits that must be zero.
  assign addr_idx = IDX_W'(ALUMemAdd >> OFF_W);
  assign legal    = ((ALUMemAdd & ADDR_WIDTH'(LANES - 1)) == '0) &&
                    ((ALUMemAdd >> (OFF_W + IDX_W)) == '0);
  assign wr_lanes = (writeEn && legal) ? byteEn : '0;

  always_ff @(posedge CLK) begin
    if (RST) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx == IDX_W'(DEPTH - 1)) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == READY);
    memReady = ready;
  end

  always_ff @(posedge CLK) begin
    if (RST)                 clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + IDX_W'(1);
  end

  always_comb begin
    arr_idx   = addr_idx;
    arr_en    = '0;
    arr_wdata = writeDataM;
    if (!RST) begin
      if (state == CLEAR) begin
        arr_idx   = clr_idx;
        arr_en    = '1;
        arr_wdata = '0;
      end else begin
        arr_en = wr_lanes;
      end
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (CLK),
    .index   (arr_idx),
    .lane_en (arr_en),
    .wdata   (arr_wdata),
    .rdata   (stored)
  );

`ifdef DMEM_WR_FORWARD_EN
  always_comb begin
    rd_word = stored;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_lanes[i]) rd_word[8*i +: 8] = writeDataM[8*i +: 8];
    end
  end
`else
  assign rd_word = stored;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      readDataW <= '0;
      readValid <= 1'b0;
      addrErr   <= 1'b0;
    end else begin
      readValid <= ready && readEn;
      addrErr   <= ready && (readEn || writeEn) && !legal;
      if (ready && readEn) readDataW <= legal ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_byte_data_mem.sv
// Randomised and directed checks of byte_data_mem against a word-array reference model.
module tb_byte_data_mem;

`ifdef DMEM_WR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        writeEn = 1'b0;
  logic        readEn = 1'b0;
  logic [31:0] ALUMemAdd = '0;
  logic [31:0] writeDataM = '0;
  logic [3:0]  byteEn = '0;
  logic [31:0] readDataW;
  logic        readValid;
  logic        addrErr;
  logic        memReady;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [256];
  logic [31:0] exp_rd = '0;

  byte_data_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .writeEn    (writeEn),
    .readEn     (readEn),
    .ALUMemAdd  (ALUMemAdd),
    .writeDataM (writeDataM),
    .byteEn     (byteEn),
    .readDataW  (readDataW),
    .readValid  (readValid),
    .addrErr    (addrErr),
    .memReady   (memReady)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timed out");
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    writeEn = 1'b0; readEn = 1'b0; ALUMemAdd = '0; writeDataM = '0; byteEn = '0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    cycle();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    exp_rd = '0;
    chk("rst_ready", {31'b0, memReady}, 32'd0);
    chk("rst_valid", {31'b0, readValid}, 32'd0);
    chk("rst_err", {31'b0, addrErr}, 32'd0);
    chk("rst_data", readDataW, 32'd0);
    RST = 1'b0;
  endtask

  // Requests are thrown at the block while it clears; none may be acted on.
  task automatic wait_ready();
    int n = 0;
    logic noisy = 1'b0;
    while (memReady !== 1'b1 && n < 400) begin
      writeEn    = 1'($urandom);
      readEn     = 1'($urandom);
      ALUMemAdd  = {22'b0, 8'($urandom), 2'b00};
      writeDataM = $urandom;
      byteEn     = 4'hF;
      cycle();
      n++;
      if (readValid !== 1'b0 || addrErr !== 1'b0) noisy = 1'b1;
    end
    idle();
    chk("clear_cycles", 32'(n), 32'd256);
    chk("clear_quiet", {31'b0, noisy}, 32'd0);
  endtask

  task automatic req(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be);
    logic        ok;
    int          idx;
    logic [31:0] old_w, new_w;
    ok    = (addr % 4 == 0) && (addr < 32'd1024);
    idx   = int'(addr / 4) % 256;
    old_w = ok ? mem_m[idx] : 32'd0;
    new_w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
    if (re) exp_rd = !ok ? 32'd0 : ((we && FWD) ? new_w : old_w);
    writeEn = we; readEn = re; ALUMemAdd = addr; writeDataM = wd; byteEn = be;
    cycle();
    if (we && ok) mem_m[idx] = new_w;
    chk("valid", {31'b0, readValid}, {31'b0, re});
    chk("err", {31'b0, addrErr}, {31'b0, (we || re) && !ok});
    chk("data", readDataW, exp_rd);
    chk("ready", {31'b0, memReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    idle();
    apply_reset();
    wait_ready();

    req(1'b0, 1'b1, 32'h40, '0, 4'h0);
    chk("read_0x40", readDataW, 32'h0);

    req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b0, 1'b1, 32'h10, '0, 4'h0);
    chk("full_write", readDataW, 32'hDEADBEEF);

    req(1'b1, 1'b0, 32'h10, 32'h11223344, 4'h5);
    idle(); cycle();
    chk("hold_data", readDataW, 32'hDEADBEEF);
    chk("hold_valid", {31'b0, readValid}, 32'd0);
    req(1'b0, 1'b1, 32'h10, '0, 4'h0);
    chk("partial_write", readDataW, 32'hDE22BE44);

    req(1'b0, 1'b1, 32'h06, '0, 4'h0);
    chk("misaligned_err", {31'b0, addrErr}, 32'd1);
    chk("misaligned_data", readDataW, 32'h0);
    req(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 4'hF);
    chk("range_err", {31'b0, addrErr}, 32'd1);
    req(1'b1, 1'b1, 32'h12, 32'h55555555, 4'hF);
    req(1'b0, 1'b1, 32'h00, '0, 4'h0);
    chk("alias_untouched", readDataW, 32'h0);
    req(1'b0, 1'b1, 32'h10, '0, 4'h0);
    chk("misaligned_untouched", readDataW, 32'hDE22BE44);

    req(1'b1, 1'b0, 32'h20, 32'hAAAAAAAA, 4'hF);
    req(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    chk("rw_same", readDataW, FWD ? 32'h12345678 : 32'hAAAAAAAA);
    req(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    chk("noop_write", readDataW, 32'h12345678);
    req(1'b1, 1'b1, 32'h20, 32'h0000BB00, 4'h2);
    chk("rw_partial", readDataW, FWD ? 32'h1234BB78 : 32'h12345678);

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 8)       a = {26'b0, 4'($urandom), 2'b00};
      else if (kind == 8) a = {26'b0, 4'($urandom), 2'($urandom_range(1, 3))};
      else                a = 32'h400 | ($urandom & 32'hFFFF_FFFC);
      req(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
    end
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 32'(i * 4), '0, 4'h0);

    // Reset while ready, after non-zero data is stored and returned.
    req(1'b0, 1'b1, 32'h20, '0, 4'h0);
    apply_reset();
    wait_ready();
    req(1'b0, 1'b1, 32'h20, '0, 4'h0);
    chk("cleared_after_ready_rst", readDataW, 32'h0);

    req(1'b1, 1'b0, 32'h3FC, 32'h87654321, 4'hF);
    apply_reset();
    for (int i = 0; i < 100; i++) cycle();
    chk("mid_clear_ready", {31'b0, memReady}, 32'd0);
    apply_reset();
    wait_ready();
    req(1'b0, 1'b1, 32'h3FC, '0, 4'h0);
    chk("cleared_after_mid_rst", readDataW, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/byte_data_mem.md
BYTE_DATA_MEM -- requirements
Module: byte_data_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the byte address bus.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 256: number of words; a power of 2.
REQ-004 SHALL have one clock and a synchronous, active-high reset. Ports are named CLK and RST.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 writeEn  input  1  write request.
REQ-008 readEn  input  1  read request.
REQ-009 ALUMemAdd  input  ADDR_WIDTH  byte address.
REQ-010 writeDataM  input  DATA_WIDTH  write data.
REQ-011 byteEn  input  DATA_WIDTH/8  per-byte write enable.
REQ-012 readDataW  output  DATA_WIDTH  registered read data.
REQ-013 readValid  output  1  one-cycle pulse; readDataW is valid.
REQ-014 addrErr  output  1  one-cycle pulse; the previous request was illegal.
REQ-015 memReady  output  1  high when the block accepts requests.

Function
REQ-016 The block SHALL have FSM states CLEAR and READY. Reset enters CLEAR.
- CLEAR: write 0 to one word per cycle, index 0..DEPTH-1. After index DEPTH-1, go to READY.
- memReady is high only in READY.
REQ-017 In CLEAR, writeEn and readEn SHALL be ignored. No readValid or addrErr is generated.
REQ-018 In READY, the address SHALL be decoded as follows:
- Word index = ALUMemAdd[log2(DATA_WIDTH/8)+log2(DEPTH)-1 : log2(DATA_WIDTH/8)].
- Offset = the low log2(DATA_WIDTH/8) bits.
REQ-019 A request SHALL be illegal when the offset is nonzero, or when any ALUMemAdd bit above the word-index field is 1.
REQ-020 For a legal write, each byte i with byteEn[i]=1 SHALL be updated at the rising edge. Other bytes are unchanged.
REQ-021 A legal read SHALL have 1-cycle latency:
- readDataW is updated and readValid pulses high in the cycle after readEn is sampled.
REQ-022 Without a new read, readDataW SHALL hold its last value.
REQ-023 An illegal request (read, write or both) SHALL behave as follows:
- The write is suppressed.
- addrErr pulses high in the next cycle.
- An illegal read also pulses readValid with readDataW = 0.
REQ-024 When writeEn and readEn are both high to the same legal address, the read result SHALL follow the Configuration section.
REQ-025 When writeEn and readEn are both high to different addresses, both operations SHALL complete in the same cycle.
REQ-026 byteEn = 0 with writeEn = 1 SHALL be a legal no-op write.

Reset
REQ-027 RST = 1 SHALL do all of the following:
- Set readDataW = 0, readValid = 0, addrErr = 0, memReady = 0.
- Set the clear index to 0 and the state to CLEAR.
REQ-028 RST asserted during CLEAR or READY SHALL restart the clear sequence from index 0.
REQ-029 Memory contents SHALL be all-zero once memReady first rises after reset.

Configuration
REQ-030 Macro DMEM_WR_FORWARD_EN controls read-during-write behaviour on the same address.
- Defined: the read returns the new word: written bytes come from writeDataM, other bytes from stored data.
- Undefined: the read returns the stored data from before the write.

Structure
REQ-031 Package dmem_pkg SHALL hold:
- the FSM state enum (CLEAR, READY);
- localparam functions for byte-lane count and offset width.
REQ-032 Sub-module dmem_array SHALL hold the storage.
- Ports: clock, word index, byte-lane write enables, write data, asynchronous read port.
- byte_data_mem holds the FSM, decode, forwarding and output registers.

Verification
REQ-033 Reset: RST high 1 cycle, then low. Required response:
- memReady = 0 for exactly DEPTH cycles (256), then 1.
- A read of address 0x40 returns 0x00000000.
REQ-034 Full write, then read:
- Write 0xDEADBEEF to 0x10 with byteEn = 0xF; next cycle read 0x10.
- readValid and readDataW = 0xDEADBEEF appear in the cycle after readEn.
REQ-035 Partial write:
- Address 0x10 holds 0xDEADBEEF; write 0x11223344 with byteEn = 0x5.
- A later read returns 0xDE22BE44.
REQ-036 Illegal addresses, with no memory change:
- Read 0x06 gives addrErr = 1, readValid = 1, readDataW = 0.
- Write to 0x400 with DEPTH = 256 gives addrErr = 1.
REQ-037 Same-cycle read and write to 0x20:
- Stored value 0xAAAAAAAA; write 0x12345678 with byteEn = 0xF.
- Returns 0x12345678 with DMEM_WR_FORWARD_EN, 0xAAAAAAAA without.
REQ-038 Reset mid-operation: RST asserted at clear index 100 and again during READY. Required response:
- In both cases the clear restarts at index 0.
- memReady returns 256 cycles after RST falls.
